// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encodings and
// default widths / reset address.
package fetch_pkg;

    localparam int ADDR_W_DEF   = 10;
    localparam int DATA_W_DEF   = 16;
    localparam int RESET_PC_DEF = 0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection for the fetch unit: absolute jump beats relative branch,
// which beats sequential advance. All arithmetic wraps at 2^ADDR_W.
module pc_next_calc
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] instr_pc,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] pc_change,
    output logic [ADDR_W-1:0] pc_next
);

    // Priority mux; the displacement is two's complement, so a plain add
    // truncated to ADDR_W gives the right result for negative offsets.
    always_comb begin
        pc_next = instr_pc + ADDR_W'(1);
        if (jump_en) begin
            pc_next = jump_target;
        end else if (branch_taken) begin
            pc_next = instr_pc + pc_change;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one read to external instruction memory,
// captures the returned word one cycle later and presents it to the decoder
// until it is accepted, then computes the next fetch address.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   FETCH | mem_rd asserted with mem_addr = pc
//   WAIT  | memory data arrives; latch it with its pc
//   HOLD  | instruction presented (instr_valid); leave on handshake
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] PC_change,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;

    // Strobes are gated by reset_n so nothing escapes while reset is held,
    // even before the first reset edge has loaded the state register.
    assign mem_rd      = reset_n & (state == FETCH);
    assign instr_valid = reset_n & (state == HOLD);
    assign mem_addr    = pc;

    pc_next_calc #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_calc (
        .instr_pc     (instr_pc),
        .jump_en      (jump_en),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .pc_change    (PC_change),
        .pc_next      (pc_next)
    );

    // Fetch FSM; redirect inputs only matter on the HOLD handshake edge,
    // and only one read is ever in flight because FETCH lasts one cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= FETCH;
            pc          <= ADDR_W'(RESET_PC);
            instruction <= '0;
            instr_pc    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    state <= WAIT;
                end
                WAIT: begin
                    instruction <= mem_data;
                    instr_pc    <= pc;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (instr_ready) begin
                        pc    <= pc_next;
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule
